// File: rtl/hour_counter.sv
// Mod-MODULUS hour counter fed by the minutes-stage carry plus Add/Subtract buttons.
// Define TWELVE_HOUR_EN to add the registered 12-hour display outputs (MODULUS must be 24).
module hour_counter #(
  parameter int unsigned MODULUS = 24,
  parameter int unsigned WIDTH   = 5
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic             Carry_in,
  input  logic             Add,
  input  logic             Subtract,
  output logic             Day_out,
  output logic [0:WIDTH-1] count,
  output logic [1:0]       Tens,
  output logic [3:0]       Units
`ifdef TWELVE_HOUR_EN
  ,
  output logic             Hour12_tens,
  output logic [3:0]       Hour12_units,
  output logic             Pm
`endif
);

  localparam int unsigned SumW = WIDTH + 2;
  localparam logic [SumW-1:0] Mod1 = SumW'(MODULUS);
  localparam logic [SumW-1:0] Mod2 = SumW'(2 * MODULUS);

  // Bit 0: carry, bit 1: add, bit 2: subtract.
  logic [2:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, evt;

  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             day_q, day_d;
  logic [SumW-1:0]  sum, wrapped;

  always_comb begin
    s1_d   = {Subtract, Add, Carry_in};
    s2_d   = s1_q;
    prev_d = s2_q;
    evt    = s2_q & ~prev_q;

    // Bias by MODULUS so a -1 delta never goes negative; sum spans 0..2*MODULUS+1.
    sum = SumW'(count_q) + Mod1 + SumW'(evt[0]) + SumW'(evt[1]) - SumW'(evt[2]);
    if (sum >= Mod2) begin
      wrapped = sum - Mod2;
    end else if (sum >= Mod1) begin
      wrapped = sum - Mod1;
    end else begin
      wrapped = sum;
    end

    count_d = wrapped[WIDTH-1:0];
    day_d   = evt[0] && (sum >= Mod2);
    tens_d  = 2'(count_d / 10);
    units_d = 4'(count_d % 10);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      s1_q    <= '1;
      s2_q    <= '1;
      prev_q  <= '1;
      count_q <= '0;
      tens_q  <= '0;
      units_q <= '0;
      day_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      day_q   <= day_d;
    end
  end

  assign count   = count_q;
  assign Tens    = tens_q;
  assign Units   = units_q;
  assign Day_out = day_q;

`ifdef TWELVE_HOUR_EN
  logic [WIDTH-1:0] h12;
  logic             h12_tens_q, h12_tens_d, pm_q, pm_d;
  logic [3:0]       h12_units_q, h12_units_d;

  always_comb begin
    h12 = count_d;
    if (count_d == '0) begin
      h12 = WIDTH'(12);
    end else if (count_d > WIDTH'(12)) begin
      h12 = count_d - WIDTH'(12);
    end
    h12_tens_d  = (h12 >= WIDTH'(10));
    h12_units_d = h12_tens_d ? 4'(h12 - WIDTH'(10)) : 4'(h12);
    pm_d        = (count_d >= WIDTH'(12));
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      h12_tens_q  <= 1'b1;
      h12_units_q <= 4'd2;
      pm_q        <= 1'b0;
    end else begin
      h12_tens_q  <= h12_tens_d;
      h12_units_q <= h12_units_d;
      pm_q        <= pm_d;
    end
  end

  assign Hour12_tens  = h12_tens_q;
  assign Hour12_units = h12_units_q;
  assign Pm           = pm_q;
`endif

endmodule

// File: tb/tb_hour_counter.sv
// Directed self-checking bench for hour_counter; mirrors the TWELVE_HOUR_EN build option.
module tb_hour_counter;

  logic       clk;
  logic       Reset_N;
  logic       Carry_in;
  logic       Add;
  logic       Subtract;
  logic       Day_out;
  logic [0:4] count;
  logic [1:0] Tens;
  logic [3:0] Units;
`ifdef TWELVE_HOUR_EN
  logic       Hour12_tens;
  logic [3:0] Hour12_units;
  logic       Pm;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  hour_counter #(
    .MODULUS(24),
    .WIDTH  (5)
  ) u_dut (
    .Clk         (clk),
    .Reset_N     (Reset_N),
    .Carry_in    (Carry_in),
    .Add         (Add),
    .Subtract    (Subtract),
    .Day_out     (Day_out),
    .count       (count),
    .Tens        (Tens),
    .Units       (Units)
`ifdef TWELVE_HOUR_EN
    ,
    .Hour12_tens (Hour12_tens),
    .Hour12_units(Hour12_units),
    .Pm          (Pm)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_cnt, input int exp_day);
    check_eq({tag, "_count"}, int'(count), exp_cnt);
    check_eq({tag, "_tens"}, int'(Tens), exp_cnt / 10);
    check_eq({tag, "_units"}, int'(Units), exp_cnt % 10);
    check_eq({tag, "_day"}, int'(Day_out), exp_day);
  endtask

`ifdef TWELVE_HOUR_EN
  task automatic check_12(input string tag, input int t, input int u, input int p);
    check_eq({tag, "_h12t"}, int'(Hour12_tens), t);
    check_eq({tag, "_h12u"}, int'(Hour12_units), u);
    check_eq({tag, "_pm"}, int'(Pm), p);
  endtask
`endif

  // Raise the chosen inputs, verify the k+2 update latency, the one-cycle Day_out, then drop them.
  task automatic apply_evt(input logic c, input logic a, input logic s,
                           input int exp_cnt, input int exp_day, input string tag);
    @(negedge clk);
    Carry_in = c;
    Add      = a;
    Subtract = s;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_pre"}, int'(count), cur);
    @(negedge clk);
    check_outputs(tag, exp_cnt, exp_day);
    @(negedge clk);
    check_eq({tag, "_dayoff"}, int'(Day_out), 0);
    Carry_in = 1'b0;
    Add      = 1'b0;
    Subtract = 1'b0;
    repeat (4) @(negedge clk);
    cur = exp_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset_N = 1'b0;
    @(negedge clk);
    Reset_N = 1'b1;
    cur = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    Reset_N  = 1'b0;
    Carry_in = 1'b1;
    Add      = 1'b0;
    Subtract = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0);
`ifdef TWELVE_HOUR_EN
    check_12("reset", 1, 2, 0);
`endif

    // Carry held high through reset release must not count.
    Reset_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("held_hi%0d_count", i), int'(count), 0);
      check_eq($sformatf("held_hi%0d_day", i), int'(Day_out), 0);
    end
    Carry_in = 1'b0;
    repeat (3) @(negedge clk);
    apply_evt(1'b1, 1'b0, 1'b0, 1, 0, "first_carry");

    // Full day of carries: Day_out only on 23 -> 0.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      apply_evt(1'b1, 1'b0, 1'b0, i % 24, (i == 24) ? 1 : 0, $sformatf("carry%0d", i));
    end

    apply_evt(1'b0, 1'b0, 1'b1, 23, 0, "sub_wrap");
    apply_evt(1'b0, 1'b1, 1'b0, 0, 0, "add_wrap");

    apply_evt(1'b0, 1'b0, 1'b1, 23, 0, "sub_a");
    apply_evt(1'b0, 1'b0, 1'b1, 22, 0, "sub_b");
    apply_evt(1'b1, 1'b1, 1'b0, 0, 1, "carry_add_22");
    apply_evt(1'b0, 1'b0, 1'b1, 23, 0, "sub_c");
    apply_evt(1'b1, 1'b1, 1'b0, 1, 1, "carry_add_23");
    apply_evt(1'b0, 1'b0, 1'b1, 0, 0, "sub_d");
    for (int i = 1; i <= 5; i++) begin
      apply_evt(1'b0, 1'b1, 1'b0, i, 0, $sformatf("add_to5_%0d", i));
    end
    apply_evt(1'b0, 1'b1, 1'b1, 5, 0, "add_sub_cancel");
    apply_evt(1'b1, 1'b0, 1'b1, 5, 0, "carry_sub");

    for (int i = 6; i <= 15; i++) begin
      apply_evt(1'b0, 1'b1, 1'b0, i, 0, $sformatf("add_to15_%0d", i));
    end

    // Reset lands between the s1 capture and the update edge.
    @(negedge clk);
    Add = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    Reset_N = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0);
    repeat (2) @(negedge clk);
    check_outputs("rst_held", 0, 0);
    Reset_N = 1'b1;
    cur = 0;
    repeat (6) @(negedge clk);
    check_outputs("rst_release_add_hi", 0, 0);
    Add = 1'b0;
    repeat (3) @(negedge clk);
    apply_evt(1'b0, 1'b1, 1'b0, 1, 0, "post_reset_add");

`ifdef TWELVE_HOUR_EN
    do_reset();
    check_12("h00", 1, 2, 0);
    for (int i = 1; i <= 11; i++) begin
      apply_evt(1'b0, 1'b1, 1'b0, i, 0, $sformatf("h12_add%0d", i));
    end
    check_12("h11", 1, 1, 0);
    apply_evt(1'b0, 1'b1, 1'b0, 12, 0, "h12_add12");
    check_12("h12", 1, 2, 1);
    apply_evt(1'b0, 1'b1, 1'b0, 13, 0, "h12_add13");
    check_12("h13", 0, 1, 1);
    for (int i = 14; i <= 23; i++) begin
      apply_evt(1'b0, 1'b1, 1'b0, i, 0, $sformatf("h12_add%0d", i));
    end
    check_12("h23", 1, 1, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
